// File: rtl/ram_byte_sequencer_if.sv
// ram_byte_sequencer_if -- bundles the CPU-side request bus and the byte-wide
// SRAM bus of ram_byte_sequencer.
//   slave  : the sequencer (takes CPU requests and SRAM responses, drives
//            ram_load/ram_ready/ram_busy/ram_err and the SRAM strobes)
//   master : the environment (CPU requester plus SRAM device)
interface ram_byte_sequencer_if;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [1:0]  ram_width;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        ram_busy;
    logic        ram_err;
    logic [31:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_re;
    logic        sram_we;
    logic [7:0]  sram_rdata;
    logic        sram_ack;

    modport slave (
        input  ram_addr, ram_store, ram_width, ram_ren, ram_wen,
        input  sram_rdata, sram_ack,
        output ram_load, ram_ready, ram_busy, ram_err,
        output sram_addr, sram_wdata, sram_re, sram_we
    );

    modport master (
        output ram_addr, ram_store, ram_width, ram_ren, ram_wen,
        output sram_rdata, sram_ack,
        input  ram_load, ram_ready, ram_busy, ram_err,
        input  sram_addr, sram_wdata, sram_re, sram_we
    );
endinterface

// File: rtl/ram_byte_sequencer.sv
// ram_byte_sequencer -- splits a byte/half/word CPU access into 1, 2 or 4
// little-endian byte transfers on a byte-wide SRAM with an ack handshake.
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   bus (slave)    ram_addr/ram_store/ram_width/ram_ren/ram_wen in,
//                  ram_load/ram_ready/ram_busy/ram_err out,
//                  sram_addr/sram_wdata/sram_re/sram_we out,
//                  sram_rdata/sram_ack in
// Parameter TIMEOUT_CYCLES: cycles a byte may wait for sram_ack before the
// request is terminated with ram_err.
// Optional macro RAM_MISALIGN_TRAP_EN: misaligned half/word accesses complete
// with ram_err and no SRAM traffic; otherwise they proceed byte by byte.
module ram_byte_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_byte_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [1:0]  k;          // index of the byte in flight
    logic [1:0]  k_last;     // index of the final byte (N-1)
    logic        op_wr;
    logic [23:0] store_q;    // store bytes not yet presented on sram_wdata
    logic [31:0] wait_cnt;

    logic [1:0]  req_last_c;
    logic        req_bad_c;
    logic        req_c;
    logic        timeout_c;

    // Request decode: byte count and whether the request must be refused.
    always_comb begin
        req_last_c = 2'd0;
        req_bad_c  = 1'b0;
        case (bus.ram_width)
            2'b00:   req_last_c = 2'd0;
            2'b01:   req_last_c = 2'd1;
            2'b10:   req_last_c = 2'd3;
            default: req_bad_c  = 1'b1;
        endcase
`ifdef RAM_MISALIGN_TRAP_EN
        if (bus.ram_width == 2'b01 && bus.ram_addr[0])
            req_bad_c = 1'b1;
        if (bus.ram_width == 2'b10 && bus.ram_addr[1:0] != 2'b00)
            req_bad_c = 1'b1;
`endif
    end

    assign req_c     = bus.ram_ren | bus.ram_wen;
    // Fires on the last permitted wait cycle so DONE follows TIMEOUT_CYCLES
    // unacknowledged strobe cycles.
    assign timeout_c = (wait_cnt + 32'd1) >= TIMEOUT_CYCLES;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            k              <= 2'd0;
            k_last         <= 2'd0;
            op_wr          <= 1'b0;
            store_q        <= 24'd0;
            wait_cnt       <= 32'd0;
            bus.ram_load   <= 32'd0;
            bus.ram_ready  <= 1'b0;
            bus.ram_busy   <= 1'b0;
            bus.ram_err    <= 1'b0;
            bus.sram_addr  <= 32'd0;
            bus.sram_wdata <= 8'd0;
            bus.sram_re    <= 1'b0;
            bus.sram_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ram_ready <= 1'b0;
                    bus.ram_err   <= 1'b0;
                    if (req_c) begin
                        // Write wins when both strobes are requested.
                        op_wr          <= bus.ram_wen;
                        k              <= 2'd0;
                        k_last         <= req_last_c;
                        wait_cnt       <= 32'd0;
                        bus.sram_addr  <= bus.ram_addr;
                        bus.sram_wdata <= bus.ram_store[7:0];
                        store_q        <= bus.ram_store[31:8];
                        bus.ram_busy   <= 1'b1;
                        if (!bus.ram_wen)
                            bus.ram_load <= 32'd0;
                        if (req_bad_c) begin
                            state         <= DONE;
                            bus.ram_ready <= 1'b1;
                            bus.ram_err   <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            bus.sram_we <= bus.ram_wen;
                            bus.sram_re <= ~bus.ram_wen;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.sram_ack) begin
                        wait_cnt <= 32'd0;
                        if (!op_wr)
                            bus.ram_load[{k, 3'b000} +: 8] <= bus.sram_rdata;
                        if (k == k_last) begin
                            state         <= DONE;
                            bus.sram_re   <= 1'b0;
                            bus.sram_we   <= 1'b0;
                            bus.ram_ready <= 1'b1;
                        end else begin
                            // Strobe stays up; only address and data move on.
                            k              <= k + 2'd1;
                            bus.sram_addr  <= bus.sram_addr + 32'd1;
                            bus.sram_wdata <= store_q[7:0];
                            store_q        <= {8'h00, store_q[23:8]};
                        end
                    end else if (timeout_c) begin
                        state         <= DONE;
                        bus.sram_re   <= 1'b0;
                        bus.sram_we   <= 1'b0;
                        bus.ram_ready <= 1'b1;
                        bus.ram_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    k             <= 2'd0;
                    wait_cnt      <= 32'd0;
                    bus.ram_ready <= 1'b0;
                    bus.ram_err   <= 1'b0;
                    bus.ram_busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.sram_re  <= 1'b0;
                    bus.sram_we  <= 1'b0;
                    bus.ram_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_sequencer.sv
// Scoreboard bench for ram_byte_sequencer: stimulus pushes expected byte
// transfers and completions; SRAM-model and completion monitors pop and check.
module tb_ram_byte_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_byte_sequencer_if bus();

    ram_byte_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] load;
        logic        err;
        int          lat;
        int          cyc0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [7:0]  wdata;
    } byte_t;

    resp_t      resp_q[$];
    byte_t      byte_q[$];
    logic [7:0] mem [bit [31:0]];

    int n_test = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ack_delay = 0;
    bit ack_never = 1'b0;
    int wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_test++;
        n_fail++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endtask

    task automatic push_byte(input logic [31:0] a, input logic we, input logic [7:0] d);
        byte_t b;
        b.addr = a; b.we = we; b.re = ~we; b.wdata = d;
        byte_q.push_back(b);
    endtask

    // Presents a request for one cycle and records its expected completion.
    task automatic issue(input logic r, input logic w, input logic [1:0] wd,
                         input logic [31:0] a, input logic [31:0] s,
                         input logic [31:0] exp_load, input logic exp_err, input int lat);
        resp_t e;
        @(posedge clk); #1;
        bus.ram_ren = r; bus.ram_wen = w; bus.ram_width = wd;
        bus.ram_addr = a; bus.ram_store = s;
        e.load = exp_load; e.err = exp_err; e.lat = lat; e.cyc0 = cyc;
        resp_q.push_back(e);
        @(posedge clk); #1;
        bus.ram_ren = 1'b0; bus.ram_wen = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget = 100;
        while (resp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            fail_now({name, "_timeout"});
            resp_q.delete();
        end
    endtask

    // SRAM model and byte-transfer monitor.
    always @(negedge clk) begin
        byte_t b;
        if (rst) begin
            bus.sram_ack = 1'b0;
            wcnt = 0;
        end else if (bus.sram_re || bus.sram_we) begin
            if (!ack_never && wcnt >= ack_delay) begin
                if (byte_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    b = byte_q.pop_front();
                    chk("byte_addr", bus.sram_addr, b.addr);
                    chk("byte_we", 32'(bus.sram_we), 32'(b.we));
                    chk("byte_re", 32'(bus.sram_re), 32'(b.re));
                    if (b.we) chk("byte_wdata", 32'(bus.sram_wdata), 32'(b.wdata));
                end
                if (bus.sram_we) mem[bus.sram_addr] = bus.sram_wdata;
                bus.sram_rdata = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 8'h00;
                bus.sram_ack = 1'b1;
                wcnt = 0;
            end else begin
                if (byte_q.size() == 0 && !ack_never) fail_now("unexpected_strobe");
                bus.sram_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.sram_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        resp_t r;
        if (!rst && bus.ram_ready) begin
            if (resp_q.size() == 0) begin
                fail_now("unexpected_ram_ready");
            end else begin
                r = resp_q.pop_front();
                chk("ram_load", bus.ram_load, r.load);
                chk("ram_err", 32'(bus.ram_err), 32'(r.err));
                chk("ram_busy_at_ready", 32'(bus.ram_busy), 32'd1);
                if (r.lat >= 0) chk("latency", 32'(cyc - r.cyc0), 32'(r.lat));
            end
        end
    end

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        bus.ram_ren = 1'b0; bus.ram_wen = 1'b0; bus.ram_width = 2'b00;
        bus.ram_addr = 32'd0; bus.ram_store = 32'd0;
        bus.sram_ack = 1'b0; bus.sram_rdata = 8'd0;
        mem[32'h202] = 8'h34; mem[32'h203] = 8'h12;
        mem[32'h601] = 8'h11; mem[32'h602] = 8'h22;
        mem[32'h603] = 8'h33; mem[32'h604] = 8'h44;

        // Reset state
        @(negedge clk); #1;
        chk("rst_load", bus.ram_load, 32'd0);
        chk("rst_ready", 32'(bus.ram_ready), 32'd0);
        chk("rst_busy", 32'(bus.ram_busy), 32'd0);
        chk("rst_err", 32'(bus.ram_err), 32'd0);
        chk("rst_strobes", 32'({bus.sram_re, bus.sram_we}), 32'd0);
        chk("rst_sram_addr", bus.sram_addr, 32'd0);
        chk("rst_sram_wdata", 32'(bus.sram_wdata), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Word write, ack tied high
        push_byte(32'h100, 1'b1, 8'hEF); push_byte(32'h101, 1'b1, 8'hBE);
        push_byte(32'h102, 1'b1, 8'hAD); push_byte(32'h103, 1'b1, 8'hDE);
        issue(1'b0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5);
        wait_done("word_write");

        // Half read with 2-cycle ack delay; a request mid-access is ignored
        ack_delay = 2;
        push_byte(32'h202, 1'b0, 8'h00); push_byte(32'h203, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 32'h00001234, 1'b0, 7);
        @(posedge clk); #1;
        bus.ram_wen = 1'b1; bus.ram_width = 2'b00; bus.ram_addr = 32'h500; bus.ram_store = 32'h99;
        @(posedge clk); #1;
        bus.ram_wen = 1'b0;
        wait_done("half_read_delay");
        ack_delay = 0;

        // Both strobes requested: write wins
        push_byte(32'h300, 1'b1, 8'hA5);
        issue(1'b1, 1'b1, 2'b00, 32'h300, 32'h000000A5, 32'h00001234, 1'b0, 2);
        wait_done("write_wins");

        push_byte(32'h300, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 32'h000000A5, 1'b0, 2);
        wait_done("byte_read");

        push_byte(32'h102, 1'b0, 8'h00); push_byte(32'h103, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 3);
        wait_done("half_read");

        // Ack never comes: timeout after 4 strobe cycles
        ack_never = 1'b1;
        issue(1'b0, 1'b1, 2'b10, 32'h400, 32'h01020304, 32'h0000DEAD, 1'b1, 5);
        wait_done("timeout");
        #2;
        chk("timeout_strobe_low", 32'({bus.sram_re, bus.sram_we}), 32'd0);
        chk("timeout_busy_low", 32'(bus.ram_busy), 32'd0);
        ack_never = 1'b0;

        // Ack just inside the timeout window
        ack_delay = 3;
        push_byte(32'h401, 1'b1, 8'h77);
        issue(1'b0, 1'b1, 2'b00, 32'h401, 32'h00000077, 32'h0000DEAD, 1'b0, 5);
        wait_done("ack_at_limit");
        ack_delay = 0;

        // Reserved width
        issue(1'b1, 1'b0, 2'b11, 32'h800, 32'h0, 32'h0, 1'b1, 1);
        wait_done("width_reserved");

        // Misaligned word read
`ifdef RAM_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 2'b10, 32'h101, 32'h0, 32'h0, 1'b1, 1);
        held = 32'h0;
`else
        push_byte(32'h601, 1'b0, 8'h00); push_byte(32'h602, 1'b0, 8'h00);
        push_byte(32'h603, 1'b0, 8'h00); push_byte(32'h604, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b10, 32'h601, 32'h0, 32'h44332211, 1'b0, 5);
        held = 32'h44332211;
`endif
        wait_done("misaligned_word");

        // Address wrap on a half write at the top of the address space
`ifdef RAM_MISALIGN_TRAP_EN
        issue(1'b0, 1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000BBAA, held, 1'b1, 1);
        wait_done("wrap_write");
        push_byte(32'h0, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h00000000, 1'b0, 2);
`else
        push_byte(32'hFFFFFFFF, 1'b1, 8'hAA); push_byte(32'h0, 1'b1, 8'hBB);
        issue(1'b0, 1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000BBAA, held, 1'b0, 3);
        wait_done("wrap_write");
        push_byte(32'h0, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h000000BB, 1'b0, 2);
`endif
        wait_done("wrap_read");

        // Reset during byte 2 of a word write: abandoned, no completion
        push_byte(32'h700, 1'b1, 8'h0D); push_byte(32'h701, 1'b1, 8'h0C);
        @(posedge clk); #1;
        bus.ram_wen = 1'b1; bus.ram_width = 2'b10; bus.ram_addr = 32'h700; bus.ram_store = 32'h0A0B0C0D;
        @(posedge clk); #1;
        bus.ram_wen = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_strobes", 32'({bus.sram_re, bus.sram_we}), 32'd0);
        chk("midrst_busy", 32'(bus.ram_busy), 32'd0);
        chk("midrst_ready", 32'(bus.ram_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("midrst_bytes_done", 32'(byte_q.size()), 32'd0);

        push_byte(32'h300, 1'b0, 8'h00);
        issue(1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 32'h000000A5, 1'b0, 2);
        wait_done("after_reset");

        repeat (4) @(posedge clk);
        chk("byte_queue_empty", 32'(byte_q.size()), 32'd0);
        chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
